// File: rtl/mac_vec_if.sv
// Operand/result bus for mac_vec: one valid/ready channel in (a, b), one out (result, sat).
// Both channels transfer on a rising edge where valid & ready are both high; the source holds
// valid and its payload stable until that edge, and ready may depend combinationally on state.
interface mac_vec_if #(
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  parameter int ACC_W   = 12,
  parameter int VEC_LEN = 8
);
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             sat;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, sat, count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, sat, count
  );
endinterface

// File: rtl/mac_vec.sv
// Vector multiply-accumulate: sums VEC_LEN products into a saturating accumulator and
// emits one dot product per vector, with a sticky per-vector overflow flag.
module mac_vec #(
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  parameter int ACC_W   = 12,
  parameter int VEC_LEN = 8,
  parameter bit SIGNED  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  mac_vec_if.slave   bus,
  output logic       dbg_hold_o
);
  localparam int P_W   = A_W + B_W;
  localparam int EXT_W = ACC_W + 1;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  if (ACC_W < A_W + B_W) begin : g_bad_acc_w
    $error("mac_vec: ACC_W must be >= A_W+B_W");
  end
  if (VEC_LEN < 1) begin : g_bad_vec_len
    $error("mac_vec: VEC_LEN must be >= 1");
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] result_q;
  logic [CNT_W-1:0] count_q;
  logic             sat_acc_q;
  logic             sat_q;
  logic             out_valid_q;

  logic                  in_ready_w;
  logic                  accept_w;
  logic                  last_beat_w;
  logic signed [P_W-1:0] a_s, b_s, prod_s;
  logic        [P_W-1:0] a_u, b_u, prod_u;
  logic [EXT_W-1:0]      prod_ext;
  logic [EXT_W-1:0]      acc_ext;
  logic [EXT_W-1:0]      sum_w;
  logic [ACC_W-1:0]      acc_d;
  logic                  ovf_d;

  assign in_ready_w  = (state_q == ST_ACCUM) & ~clr & ~rst;
  assign accept_w    = bus.in_valid & in_ready_w;
  assign last_beat_w = (count_q == CNT_W'(VEC_LEN - 1));

  // Operands are widened to the full product width before multiplying so no bits are lost.
  assign a_s    = P_W'($signed(bus.a));
  assign b_s    = P_W'($signed(bus.b));
  assign prod_s = a_s * b_s;
  assign a_u    = P_W'(bus.a);
  assign b_u    = P_W'(bus.b);
  assign prod_u = a_u * b_u;

  always_comb begin
    prod_ext = '0;
    acc_ext  = '0;
    sum_w    = '0;
    acc_d    = '0;
    ovf_d    = 1'b0;
    if (SIGNED) begin
      prod_ext = EXT_W'(prod_s);
      acc_ext  = {acc_q[ACC_W-1], acc_q};
    end else begin
      prod_ext = EXT_W'(prod_u);
      acc_ext  = {1'b0, acc_q};
    end
    sum_w = acc_ext + prod_ext;
    // One guard bit is enough: both addends fit in ACC_W bits of their own signedness.
    if (SIGNED) begin
      ovf_d = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    end else begin
      ovf_d = sum_w[ACC_W];
    end
    if (!ovf_d) begin
      acc_d = sum_w[ACC_W-1:0];
    end else if (SIGNED) begin
      acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_d = {ACC_W{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      sat_acc_q   <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (clr) begin
            acc_q     <= '0;
            count_q   <= '0;
            sat_acc_q <= 1'b0;
          end else if (accept_w) begin
            if (last_beat_w) begin
              result_q    <= acc_d;
              sat_q       <= sat_acc_q | ovf_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              count_q     <= '0;
              sat_acc_q   <= 1'b0;
              state_q     <= ST_HOLD;
            end else begin
              acc_q     <= acc_d;
              count_q   <= count_q + CNT_W'(1);
              sat_acc_q <= sat_acc_q | ovf_d;
            end
          end
        end
        ST_HOLD: begin
          // clr is deliberately ignored here so a finished result is never dropped.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.sat       = sat_q;
  assign bus.count     = count_q;
  assign dbg_hold_o    = (state_q == ST_HOLD);

  a_no_ready_in_hold: assert property (@(posedge clk) disable iff (rst)
    bus.out_valid |-> !bus.in_ready);

  a_result_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.result) && $stable(bus.sat)));
endmodule
